// File: rtl/sump_cmd_rx_if.sv
// Byte-stream input and command-strobe output bundle of the SUMP command assembler.
// The master drives RXD bytes and consumes commands; the slave is the assembler.
interface sump_cmd_rx_if;
  logic        str_rxd_tvalid;
  logic [7:0]  str_rxd_tdata;
  logic        str_rxd_tready;
  logic [7:0]  cmd_code;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        soft_reset;
  logic        err_timeout;

  modport master (
    output str_rxd_tvalid, str_rxd_tdata,
    input  str_rxd_tready, cmd_code, cmd_data, cmd_valid, soft_reset, err_timeout
  );

  modport slave (
    input  str_rxd_tvalid, str_rxd_tdata,
    output str_rxd_tready, cmd_code, cmd_data, cmd_valid, soft_reset, err_timeout
  );
endinterface

// File: rtl/sump_cmd_rx.sv
// SUMP command assembler: short (bit7=0) and 5-byte long commands into one strobe each.
// Optional macro SUMP_CMD_TIMEOUT_EN adds a stalled-long-command timeout with err_timeout.
module sump_cmd_rx #(
  parameter int FREQ  = 50_000_000,
  parameter int TO_US = 1000
) (
  input  logic          clk,
  input  logic          rst,
  sump_cmd_rx_if.slave  bus
);

  localparam int TOC = FREQ / 1_000_000 * TO_US;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARG   = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  state_t      state_q;
  logic        tready_q;
  logic [7:0]  opc_q;
  logic [7:0]  code_q;
  logic [31:0] data_q;
  logic [23:0] shadow_q;
  logic [1:0]  idx_q;
  logic [1:0]  idx_d;
  logic        valid_q;
  logic        soft_q;
  logic        xfer_s;

`ifdef SUMP_CMD_TIMEOUT_EN
  localparam int TMR_W = (TOC > 1) ? $clog2(TOC) : 1;
  localparam logic [TMR_W-1:0] TOC_M1 = TMR_W'(TOC - 1);
  logic [TMR_W-1:0] tmr_q;
  logic             err_q;
  assign bus.err_timeout = err_q;
`else
  logic unused_toc_s;
  assign unused_toc_s    = (TOC >= 1);
  assign bus.err_timeout = 1'b0;
`endif

  assign xfer_s         = bus.str_rxd_tvalid && tready_q;
  assign idx_d          = idx_q + 2'd1;
  assign bus.str_rxd_tready = tready_q;
  assign bus.cmd_code   = code_q;
  assign bus.cmd_data   = data_q;
  assign bus.cmd_valid  = valid_q;
  assign bus.soft_reset = soft_q;

  // Command framing FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tready_q <= 1'b0;
      opc_q    <= 8'h00;
      code_q   <= 8'h00;
      data_q   <= 32'h0000_0000;
      shadow_q <= 24'h00_0000;
      idx_q    <= 2'd0;
      valid_q  <= 1'b0;
      soft_q   <= 1'b0;
`ifdef SUMP_CMD_TIMEOUT_EN
      tmr_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      soft_q  <= 1'b0;
`ifdef SUMP_CMD_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (xfer_s) begin
            opc_q <= bus.str_rxd_tdata;
            if (!bus.str_rxd_tdata[7]) begin
              code_q   <= bus.str_rxd_tdata;
              data_q   <= 32'h0000_0000;
              valid_q  <= 1'b1;
              soft_q   <= (bus.str_rxd_tdata == 8'h00);
              tready_q <= 1'b0;
              state_q  <= ST_ISSUE;
            end else begin
              idx_q    <= 2'd0;
`ifdef SUMP_CMD_TIMEOUT_EN
              tmr_q    <= '0;
`endif
              tready_q <= 1'b1;
              state_q  <= ST_ARG;
            end
          end else begin
            tready_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        ST_ARG: begin
          if (xfer_s) begin
`ifdef SUMP_CMD_TIMEOUT_EN
            tmr_q <= '0;
`endif
            // Final byte goes straight to cmd_data; earlier ones stay hidden in the shadow.
            if (idx_q == 2'd3) begin
              code_q   <= opc_q;
              data_q   <= {bus.str_rxd_tdata, shadow_q};
              valid_q  <= 1'b1;
              soft_q   <= (opc_q == 8'h00);
              idx_q    <= 2'd0;
              tready_q <= 1'b0;
              state_q  <= ST_ISSUE;
            end else begin
              case (idx_q)
                2'd0:    shadow_q[7:0]   <= bus.str_rxd_tdata;
                2'd1:    shadow_q[15:8]  <= bus.str_rxd_tdata;
                default: shadow_q[23:16] <= bus.str_rxd_tdata;
              endcase
              idx_q <= idx_d;
            end
          end
`ifdef SUMP_CMD_TIMEOUT_EN
          else if (tmr_q == TOC_M1) begin
            err_q    <= 1'b1;
            shadow_q <= 24'h00_0000;
            idx_q    <= 2'd0;
            tmr_q    <= '0;
            tready_q <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
`else
          else begin
            state_q <= ST_ARG;
          end
`endif
        end
        ST_ISSUE: begin
          tready_q <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: begin
          tready_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sump_cmd_rx.sv
// Randomised self-checking bench for sump_cmd_rx against a byte-queue framing model.
// Timeout scenario is exercised only when SUMP_CMD_TIMEOUT_EN is defined.
module tb_sump_cmd_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sump_cmd_rx_if bus ();

  sump_cmd_rx #(.FREQ(1_000_000), .TO_US(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: accepted bytes queue up until they form a complete frame.
  logic [7:0]  mq[$];
  logic        exp_valid = 1'b0;
  logic        exp_rdy   = 1'b0;
  logic [7:0]  exp_code  = 8'h00;
  logic [31:0] exp_data  = 32'h0;
  logic        chk_err   = 1'b1;
  int          err_cnt   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_feed(input logic [7:0] b);
    mq.push_back(b);
    if (!mq[0][7]) begin
      exp_code  = mq[0];
      exp_data  = 32'h0;
      exp_valid = 1'b1;
      mq.delete();
    end else if (mq.size() == 5) begin
      exp_code  = mq[0];
      exp_data  = {mq[4], mq[3], mq[2], mq[1]};
      exp_valid = 1'b1;
      mq.delete();
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, output logic acc);
    bus.str_rxd_tvalid = v;
    bus.str_rxd_tdata  = v ? d : 8'($urandom);
    acc = v && exp_rdy;
    if (acc) model_feed(d);
    @(negedge clk);
    check_val("cmd_valid", {31'h0, bus.cmd_valid}, {31'h0, exp_valid});
    check_val("tready", {31'h0, bus.str_rxd_tready}, {31'h0, exp_rdy && !exp_valid || !exp_rdy && !exp_valid});
    check_val("cmd_code", {24'h0, bus.cmd_code}, {24'h0, exp_code});
    check_val("cmd_data", bus.cmd_data, exp_data);
    check_val("soft_reset", {31'h0, bus.soft_reset}, {31'h0, exp_valid && (exp_code == 8'h00)});
    if (chk_err) check_val("err_timeout", {31'h0, bus.err_timeout}, 32'h0);
    else if (bus.err_timeout) err_cnt++;
    exp_rdy   = !exp_valid;
    exp_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    do begin
      step(1'b1, b, acc);
      n++;
    end while (!acc && n < 20);
    if (!acc) check_val("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, acc);
  endtask

  task automatic do_reset();
    bus.str_rxd_tvalid = 1'b0;
    bus.str_rxd_tdata  = 8'h00;
    rst = 1'b1;
    #1;
    check_val("rst_valid", {31'h0, bus.cmd_valid}, 32'h0);
    check_val("rst_tready", {31'h0, bus.str_rxd_tready}, 32'h0);
    check_val("rst_code", {24'h0, bus.cmd_code}, 32'h0);
    check_val("rst_data", bus.cmd_data, 32'h0);
    check_val("rst_soft", {31'h0, bus.soft_reset}, 32'h0);
    check_val("rst_err", {31'h0, bus.err_timeout}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    exp_valid = 1'b0;
    exp_rdy   = 1'b0;
    exp_code  = 8'h00;
    exp_data  = 32'h0;
  endtask

  initial begin
    logic [7:0] b;
    bus.str_rxd_tvalid = 1'b0;
    bus.str_rxd_tdata  = 8'h00;
    #2;
    do_reset();

    // Short command straight after reset (first cycle has tready low).
    send_byte(8'h01);
    idle(2);

    // Long command, tvalid held high.
    send_byte(8'hC0); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    idle(2);

    // Five zero bytes: five soft resets.
    for (int i = 0; i < 5; i++) send_byte(8'h00);
    idle(2);

    // Zeros inside a long command are argument data.
    send_byte(8'h81);
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    idle(2);

`ifdef SUMP_CMD_TIMEOUT_EN
    send_byte(8'h82); send_byte(8'hAA);
    chk_err = 1'b0;
    err_cnt = 0;
    idle(14);
    chk_err = 1'b1;
    check_val("timeout_pulses", err_cnt, 32'd1);
    mq.delete();
    send_byte(8'h02);
    idle(2);
`else
    // Without the timeout, a long stall in ARG is harmless.
    send_byte(8'h82); send_byte(8'hAA);
    idle(30);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    idle(2);
`endif

    // Reset in the middle of a long command.
    send_byte(8'hC1); send_byte(8'h11);
    do_reset();
    send_byte(8'h03);
    idle(2);

    // Random traffic with short gaps.
    for (int i = 0; i < 300; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) b = 8'h00;
      send_byte(b);
      idle($urandom_range(0, 3));
    end
    for (int i = 0; i < 5; i++) send_byte(8'h00);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
